// File: rtl/decode_stage.sv
// decode_stage - instruction-decode stage of the pipelined MIPS core.
//
// Decodes the instruction in IF/ID, drives the register file read ports,
// forwards same-cycle writeback data into the operands, detects load-use
// hazards against the instruction in EX, and holds the ID/EX register.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   if_valid/instr/pc4   IF/ID contents
//   flush                squash the instruction in ID (redirect from EX)
//   rf_read_reg1/2       register file read addresses (rs, rt), combinational
//   rf_read_data1/2      register file read data
//   wb_write_*           writeback port, used for same-cycle bypass
//   stall                hold PC and IF/ID this cycle
//   ex_*                 ID/EX pipeline register outputs
module decode_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_instr,
  input  logic [DATA_W-1:0] if_pc4,
  input  logic              flush,
  output logic [REG_AW-1:0] rf_read_reg1,
  output logic [REG_AW-1:0] rf_read_reg2,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  input  logic [REG_AW-1:0] wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              wb_write_enable,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_dest,
  output logic [25:0]       ex_jtarget,
  output logic [2:0]        ex_alu_op,
  output logic              ex_alu_src,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic              ex_branch,
  output logic              ex_jump
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;

  assign opcode = if_instr[31:26];
  assign funct  = if_instr[5:0];
  assign rs     = if_instr[25:21];
  assign rt     = if_instr[20:16];
  assign rd     = if_instr[15:11];

  assign rf_read_reg1 = rs;
  assign rf_read_reg2 = rt;

  logic              d_valid;
  logic [2:0]        d_alu_op;
  logic              d_alu_src, d_mem_read, d_mem_write, d_reg_write;
  logic              d_mem_to_reg, d_branch, d_jump;
  logic [REG_AW-1:0] d_dest;
  logic              use_rs, use_rt;

  always_comb begin
    d_valid      = 1'b0;
    d_alu_op     = ALU_ADD;
    d_alu_src    = 1'b0;
    d_mem_read   = 1'b0;
    d_mem_write  = 1'b0;
    d_reg_write  = 1'b0;
    d_mem_to_reg = 1'b0;
    d_branch     = 1'b0;
    d_jump       = 1'b0;
    d_dest       = '0;
    use_rs       = 1'b0;
    use_rt       = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        d_valid = 1'b1;
        case (funct)
          6'h20:   d_alu_op = ALU_ADD;
          6'h22:   d_alu_op = ALU_SUB;
          6'h24:   d_alu_op = ALU_AND;
          6'h25:   d_alu_op = ALU_OR;
          6'h2A:   d_alu_op = ALU_SLT;
          default: d_valid  = 1'b0;
        endcase
        d_reg_write = d_valid;
        d_dest      = d_valid ? rd : '0;
        use_rs      = d_valid;
        use_rt      = d_valid;
      end
      OP_LW: begin
        d_valid      = 1'b1;
        d_alu_src    = 1'b1;
        d_mem_read   = 1'b1;
        d_mem_to_reg = 1'b1;
        d_reg_write  = 1'b1;
        d_dest       = rt;
        use_rs       = 1'b1;
      end
      OP_SW: begin
        d_valid     = 1'b1;
        d_alu_src   = 1'b1;
        d_mem_write = 1'b1;
        use_rs      = 1'b1;
        use_rt      = 1'b1;
      end
      OP_BEQ: begin
        d_valid  = 1'b1;
        d_alu_op = ALU_SUB;
        d_branch = 1'b1;
        use_rs   = 1'b1;
        use_rt   = 1'b1;
      end
      OP_ADDI: begin
        d_valid     = 1'b1;
        d_alu_src   = 1'b1;
        d_reg_write = 1'b1;
        d_dest      = rt;
        use_rs      = 1'b1;
      end
      OP_J: begin
        d_valid = 1'b1;
        d_jump  = 1'b1;
      end
      default: d_valid = 1'b0;
    endcase
  end

  // Register 0 reads as zero; otherwise a same-cycle writeback wins over
  // the (not yet updated) register file contents.
  function automatic logic [DATA_W-1:0] operand(input logic [REG_AW-1:0] addr,
                                                input logic [DATA_W-1:0] rdata);
    if (addr == '0)
      return '0;
    else if (wb_write_enable && (wb_write_reg == addr))
      return wb_write_data;
    else
      return rdata;
  endfunction

  logic [DATA_W-1:0] rs_data, rt_data, imm;
  assign rs_data = operand(rs, rf_read_data1);
  assign rt_data = operand(rt, rf_read_data2);
  assign imm     = {{(DATA_W-16){if_instr[15]}}, if_instr[15:0]};

  logic hazard;
  assign hazard = ex_valid && ex_mem_read && (ex_dest != '0) && if_valid &&
                  ((use_rs && (ex_dest == rs)) || (use_rt && (ex_dest == rt)));
  // A redirect discards the dependent instruction, so there is nothing to hold.
  assign stall  = hazard && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n || flush || stall || !if_valid || !d_valid) begin
      ex_valid      <= 1'b0;
      ex_pc4        <= '0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm        <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_dest       <= '0;
      ex_jtarget    <= '0;
      ex_alu_op     <= '0;
      ex_alu_src    <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_branch     <= 1'b0;
      ex_jump       <= 1'b0;
    end else begin
      ex_valid      <= 1'b1;
      ex_pc4        <= if_pc4;
      ex_rs_data    <= rs_data;
      ex_rt_data    <= rt_data;
      ex_imm        <= imm;
      ex_rs         <= rs;
      ex_rt         <= rt;
      ex_dest       <= d_dest;
      ex_jtarget    <= if_instr[25:0];
      ex_alu_op     <= d_alu_op;
      ex_alu_src    <= d_alu_src;
      ex_mem_read   <= d_mem_read;
      ex_mem_write  <= d_mem_write;
      ex_reg_write  <= d_reg_write;
      ex_mem_to_reg <= d_mem_to_reg;
      ex_branch     <= d_branch;
      ex_jump       <= d_jump;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed vectors drive IF/ID each cycle and
// push the hand-computed ID/EX contents expected after the next edge; a
// monitor pops the queue after every edge and compares the full register.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr, if_pc4;
  logic        flush;
  logic [4:0]  rf_read_reg1, rf_read_reg2;
  logic [31:0] rf_read_data1, rf_read_data2;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        wb_write_enable;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_dest;
  logic [25:0] ex_jtarget;
  logic [2:0]  ex_alu_op;
  logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;
  logic        ex_mem_to_reg, ex_branch, ex_jump;

  decode_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc4(if_pc4), .flush(flush),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .wb_write_enable(wb_write_enable), .stall(stall),
    .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_dest(ex_dest), .ex_jtarget(ex_jtarget), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_jump(ex_jump)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [25:0] jt;
    logic [2:0]  alu_op;
    logic [6:0]  ctrl;  // alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jump
  } exp_t;

  localparam logic [6:0] C_SRC = 7'b1000000;
  localparam logic [6:0] C_MR  = 7'b0100000;
  localparam logic [6:0] C_MW  = 7'b0010000;
  localparam logic [6:0] C_RW  = 7'b0001000;
  localparam logic [6:0] C_M2R = 7'b0000100;
  localparam logic [6:0] C_BR  = 7'b0000010;
  localparam logic [6:0] C_J   = 7'b0000001;
  localparam exp_t BUBBLE = '0;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    done     = 1'b0;

  function automatic exp_t mk(input logic [31:0] pc4, rsd, rtd, imm,
                              input logic [4:0] rs, rt, dest,
                              input logic [25:0] jt, input logic [2:0] op,
                              input logic [6:0] ctrl);
    exp_t e;
    e.valid = 1'b1; e.pc4 = pc4; e.rs_data = rsd; e.rt_data = rtd; e.imm = imm;
    e.rs = rs; e.rt = rt; e.dest = dest; e.jt = jt; e.alu_op = op; e.ctrl = ctrl;
    return e;
  endfunction

  // Monitor: after each edge, the ID/EX register must match the next entry.
  always @(posedge clk) begin
    exp_t  act, e;
    string nm;
    #1;
    act = {ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt,
           ex_dest, ex_jtarget, ex_alu_op,
           {ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
            ex_mem_to_reg, ex_branch, ex_jump}};
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: idex got %h required %h", nm, act, e);
      end
    end else if (!done) begin
      n_checks++;
      if (ex_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL unexpected_issue: ex_valid got %b required 0", ex_valid);
      end
    end
  end

  task automatic step(input string nm, input logic rst, v, fl,
                      input logic [31:0] instr, pc4, rd1, rd2,
                      input logic [4:0] wreg, input logic [31:0] wdata,
                      input logic we, input logic chk_stall, exp_stall,
                      input exp_t e);
    rst_n = rst; if_valid = v; flush = fl; if_instr = instr; if_pc4 = pc4;
    rf_read_data1 = rd1; rf_read_data2 = rd2;
    wb_write_reg = wreg; wb_write_data = wdata; wb_write_enable = we;
    #1;
    if (chk_stall) begin
      n_checks++;
      if (stall !== exp_stall) begin
        n_fail++;
        $display("FAIL %s_stall: stall got %b required %b", nm, stall, exp_stall);
      end
    end
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  initial begin
    //    name        rst v  fl instr         pc4       rd1       rd2       wreg wdata         we chk st expected
    step("reset0",    0, 1, 0, 32'h00221820, 32'h100, 32'd5,    32'd7,    5'd0, 32'h0,        0, 0, 0, BUBBLE);
    step("reset1",    0, 1, 0, 32'h00221820, 32'h100, 32'd5,    32'd7,    5'd0, 32'h0,        0, 1, 0, BUBBLE);
    step("add",       1, 1, 0, 32'h00221820, 32'h104, 32'd5,    32'd7,    5'd0, 32'h0,        0, 1, 0,
         mk(32'h104, 32'd5, 32'd7, 32'h1820, 5'd1, 5'd2, 5'd3, 26'h0221820, 3'b000, C_RW));
    step("bypass",    1, 1, 0, 32'h00221820, 32'h108, 32'd5,    32'd7,    5'd1, 32'hFFFFFFFF, 1, 1, 0,
         mk(32'h108, 32'hFFFFFFFF, 32'd7, 32'h1820, 5'd1, 5'd2, 5'd3, 26'h0221820, 3'b000, C_RW));
    step("reg0",      1, 1, 0, 32'h00021820, 32'h10C, 32'd5,    32'd7,    5'd0, 32'h12345678, 1, 1, 0,
         mk(32'h10C, 32'd0, 32'd7, 32'h1820, 5'd0, 5'd2, 5'd3, 26'h0021820, 3'b000, C_RW));
    step("lw",        1, 1, 0, 32'h8C220004, 32'h110, 32'h100,  32'hAA,   5'd0, 32'h0,        0, 1, 0,
         mk(32'h110, 32'h100, 32'hAA, 32'd4, 5'd1, 5'd2, 5'd2, 26'h0220004, 3'b000, C_SRC|C_MR|C_M2R|C_RW));
    step("loaduse",   1, 1, 0, 32'h00421820, 32'h114, 32'd9,    32'd9,    5'd0, 32'h0,        0, 1, 1, BUBBLE);
    step("after_stl", 1, 1, 0, 32'h00421820, 32'h114, 32'd9,    32'd9,    5'd0, 32'h0,        0, 1, 0,
         mk(32'h114, 32'd9, 32'd9, 32'h1820, 5'd2, 5'd2, 5'd3, 26'h0421820, 3'b000, C_RW));
    step("lw2",       1, 1, 0, 32'h8C220004, 32'h118, 32'h100,  32'hAA,   5'd0, 32'h0,        0, 1, 0,
         mk(32'h118, 32'h100, 32'hAA, 32'd4, 5'd1, 5'd2, 5'd2, 26'h0220004, 3'b000, C_SRC|C_MR|C_M2R|C_RW));
    step("flush_haz", 1, 1, 1, 32'h00421820, 32'h11C, 32'd9,    32'd9,    5'd0, 32'h0,        0, 1, 0, BUBBLE);
    step("addi",      1, 1, 0, 32'h2005FFFF, 32'h120, 32'h55,   32'h66,   5'd0, 32'h0,        0, 1, 0,
         mk(32'h120, 32'd0, 32'h66, 32'hFFFFFFFF, 5'd0, 5'd5, 5'd5, 26'h005FFFF, 3'b000, C_SRC|C_RW));
    step("illegal",   1, 1, 0, 32'hFC000000, 32'h124, 32'd1,    32'd2,    5'd0, 32'h0,        0, 1, 0, BUBBLE);
    step("invalid",   1, 0, 0, 32'h00221820, 32'h128, 32'd5,    32'd7,    5'd0, 32'h0,        0, 1, 0, BUBBLE);
    step("j",         1, 1, 0, 32'h08000010, 32'h12C, 32'h77,   32'h88,   5'd0, 32'h0,        0, 1, 0,
         mk(32'h12C, 32'd0, 32'd0, 32'h10, 5'd0, 5'd0, 5'd0, 26'h0000010, 3'b000, C_J));
    step("sw",        1, 1, 0, 32'hAC220008, 32'h130, 32'd3,    32'd4,    5'd2, 32'hBEEF,     1, 1, 0,
         mk(32'h130, 32'd3, 32'hBEEF, 32'd8, 5'd1, 5'd2, 5'd0, 26'h0220008, 3'b000, C_SRC|C_MW));
    step("beq",       1, 1, 0, 32'h10220003, 32'h134, 32'd3,    32'd4,    5'd0, 32'h0,        0, 1, 0,
         mk(32'h134, 32'd3, 32'd4, 32'd3, 5'd1, 5'd2, 5'd0, 26'h0220003, 3'b001, C_BR));
    step("lw3",       1, 1, 0, 32'h8C220004, 32'h138, 32'h100,  32'hAA,   5'd0, 32'h0,        0, 1, 0,
         mk(32'h138, 32'h100, 32'hAA, 32'd4, 5'd1, 5'd2, 5'd2, 26'h0220004, 3'b000, C_SRC|C_MR|C_M2R|C_RW));
    // addi writes rt, so a load into rt is not a hazard for it
    step("addi_rt",   1, 1, 0, 32'h20220001, 32'h13C, 32'h10,   32'h20,   5'd0, 32'h0,        0, 1, 0,
         mk(32'h13C, 32'h10, 32'h20, 32'd1, 5'd1, 5'd2, 5'd2, 26'h0220001, 3'b000, C_SRC|C_RW));
    step("slt",       1, 1, 0, 32'h0022182A, 32'h140, 32'd1,    32'd2,    5'd0, 32'h0,        0, 1, 0,
         mk(32'h140, 32'd1, 32'd2, 32'h182A, 5'd1, 5'd2, 5'd3, 26'h022182A, 3'b100, C_RW));
    step("lw4",       1, 1, 0, 32'h8C220004, 32'h144, 32'h100,  32'hAA,   5'd0, 32'h0,        0, 1, 0,
         mk(32'h144, 32'h100, 32'hAA, 32'd4, 5'd1, 5'd2, 5'd2, 26'h0220004, 3'b000, C_SRC|C_MR|C_M2R|C_RW));
    step("rst_mid",   0, 1, 1, 32'h00421820, 32'h148, 32'd9,    32'd9,    5'd0, 32'h0,        0, 1, 0, BUBBLE);
    step("post_rst",  1, 1, 0, 32'h00421825, 32'h14C, 32'd9,    32'd6,    5'd0, 32'h0,        0, 1, 0,
         mk(32'h14C, 32'd9, 32'd6, 32'h1825, 5'd2, 5'd2, 5'd3, 26'h0421825, 3'b011, C_RW));
    if_valid = 1'b0;
    @(negedge clk);
    done = 1'b1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending entries got %0d required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the pipelined MIPS core. It sits between the IF/ID register and the EX stage and drives the register file's two read ports. It decodes the instruction, bypasses same-cycle writeback data, detects load-use hazards, and holds the ID/EX pipeline register. The register file is the direct neighbour: this block produces its read addresses and consumes its read data.

## Interface
- DATA_W, 32, datapath width
- REG_AW, 5, register address width

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- if_valid  in  1  IF/ID holds a real instruction
- if_instr  in  DATA_W  instruction from IF/ID
- if_pc4  in  DATA_W  PC+4 of that instruction
- flush  in  1  squash the instruction in ID (taken branch/jump from EX)
- rf_read_reg1, rf_read_reg2  out  REG_AW  register file read addresses (rs, rt)
- rf_read_data1, rf_read_data2  in  DATA_W  register file read data
- wb_write_reg  in  REG_AW  WB destination (same net as register file write port)
- wb_write_data  in  DATA_W  WB data
- wb_write_enable  in  1  WB write strobe
- stall  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  ID/EX holds a real instruction
- ex_pc4, ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered operands; imm is sign-extended
- ex_rs, ex_rt, ex_dest  out  REG_AW  source and destination register numbers
- ex_jtarget  out  26  jump target field
- ex_alu_op  out  3  operation code: 000 add, 001 sub, 010 and, 011 or, 100 slt
- ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch, ex_jump  out  1  control signals

## Operation
- Supported instructions:
  - R-type (op 0). funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt. Sets reg_write; dest = rd.
  - lw 0x23: add, alu_src, mem_read, mem_to_reg, reg_write; dest = rt.
  - sw 0x2B: add, alu_src, mem_write.
  - beq 0x04: sub, branch.
  - addi 0x08: add, alu_src, reg_write; dest = rt.
  - j 0x02: jump.
- Any other opcode or funct decodes as a bubble.
- Bubble definition: ex_valid=0 and every control signal and ex_dest are 0. Data fields are don't-care but are driven to 0.
- rf_read_reg1 = if_instr[25:21] and rf_read_reg2 = if_instr[20:16], combinationally, at all times.
- Operand select, applied per port:
  - If the read address is 0, the operand is 0.
  - Else, if wb_write_enable is set and wb_write_reg equals the read address, the operand is wb_write_data.
  - Else, the operand is rf_read_data.
- Source usage:
  - rs is used by R-type, lw, sw, beq and addi.
  - rt is used by R-type, sw and beq.
- Load-use hazard: ex_valid & ex_mem_read & ex_dest≠0 & if_valid, where ex_dest matches a used source.
  - stall = hazard & ~flush.
- ID/EX update on each rising edge, in priority order:
  1. rst_n=0: clear to bubble.
  2. flush: bubble.
  3. stall: bubble. The instruction stays in IF/ID and re-decodes next cycle.
  4. if_valid=0: bubble.
  5. Otherwise load the decoded instruction.

## Timing
- Reset values: all ex_* outputs are 0 and ex_valid=0. stall=0 because it derives from ex_valid.
- Reset asserted mid-stream takes effect at the next edge and has priority over flush and stall.
- Read addresses, operand select and stall are combinational, with zero-cycle latency.
- ID to EX latency is exactly one clock.
- A load-use stall lasts exactly one cycle: after the bubble, ex_mem_read=0, so the hazard clears.
- flush in the same cycle as a hazard gives stall=0 and a bubble; the load already in EX proceeds.
- Back-to-back valid, non-hazard instructions issue one per cycle with no bubbles.

## Test plan
- Reset: hold rst_n=0 for 2 cycles while if_valid=1 and if_instr=0x00221820.
  - Required: every ex_* output is 0 and stall=0.
  - After release, the first edge loads the add.
- Decode: add $3,$1,$2 (0x00221820) with rf data 5 and 7.
  - Required next cycle: ex_valid=1, alu_op=000, ex_dest=3, ex_rs_data=5, ex_rt_data=7, reg_write=1, alu_src=0.
- Bypass: same add with wb_write_reg=1, wb_write_data=0xFFFFFFFF, wb_write_enable=1, rf_read_data1=5.
  - Required: ex_rs_data=0xFFFFFFFF.
  - Repeat with wb_write_reg=0 and instruction 0x00021820. Required: ex_rs_data=0.
- Load-use: lw $2,4($1) (0x8C220004), then add $3,$2,$2 (0x00421820).
  - Required: stall=1 for one cycle and a bubble enters EX.
  - The add then issues with stall=0.
- Flush priority: reproduce the load-use case with flush=1 in the hazard cycle.
  - Required: stall=0 and ex_valid=0 next cycle.
- Immediate and illegal instructions:
  - addi $5,$0,-1 (0x2005FFFF). Required: ex_imm=0xFFFFFFFF, alu_src=1, ex_dest=5, ex_rs_data=0.
  - 0xFC000000. Required: ex_valid=0 and all controls 0.
